// File: rtl/divider.sv
// Iterative radix-2 restoring divider with valid/ready handshakes on both sides.
// Signed and unsigned modes, fixed WIDTH-edge latency, divide-by-zero and
// signed-overflow flags. State is exposed on dbg_state for checkers.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1. in_ready is 1 only in IDLE; out_valid is 1 only in DONE, and the result
// holds stable until the edge where out_ready=1 returns the block to IDLE.
module divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  // Datapath intermediates (WIDTH+1 bits so the most-negative magnitude fits)
  logic             dvd_neg, dsr_neg;
  logic [WIDTH:0]   dvd_mag, dsr_mag;
  logic [WIDTH:0]   bit_sel;
  logic             dvd_bit;
  logic [WIDTH:0]   trial, diff;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] q_res, r_res;
  logic             is_dbz, is_ovf;

  // Operand magnitudes, one restoring step, and the sign-corrected final result
  always_comb begin
    dvd_neg = sgn_q & dvd_q[WIDTH-1];
    dsr_neg = sgn_q & dsr_q[WIDTH-1];
    dvd_mag = dvd_neg ? -{dvd_q[WIDTH-1], dvd_q} : {1'b0, dvd_q};
    dsr_mag = dsr_neg ? -{dsr_q[WIDTH-1], dsr_q} : {1'b0, dsr_q};
    // Dividend bits are consumed MSB first: step k uses bit WIDTH-1-k.
    bit_sel = ((WIDTH+1)'(1) << (WIDTH-1)) >> cnt_q;
    dvd_bit = |(dvd_mag & bit_sel);
    trial   = {rem_q, dvd_bit};
    diff    = trial - dsr_mag;
    fits    = (trial >= dsr_mag);
    rem_nxt = WIDTH'(fits ? diff : trial);
    quo_nxt = WIDTH'({quo_q, fits});
    q_res   = (dvd_neg ^ dsr_neg) ? -quo_nxt : quo_nxt;
    r_res   = dvd_neg ? -rem_nxt : rem_nxt;
    is_dbz  = (dsr_q == '0);
    is_ovf  = sgn_q && (dvd_q == {1'b1, {(WIDTH-1){1'b0}}}) && (dsr_q == '1);
    if (is_dbz) begin
      q_res = '1;
      r_res = dvd_q;
    end
  end

  // Next-state and register-update logic for the IDLE/CALC/DONE controller
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    sgn_d       = sgn_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d   = dividend;
          dsr_d   = divisor;
          sgn_d   = is_signed;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          quotient_d  = q_res;
          remainder_d = r_res;
          dbz_d       = is_dbz;
          ovf_d       = is_ovf;
          cnt_d       = '0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      sgn_q       <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      sgn_q       <= sgn_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign dbg_state   = state_q;

endmodule
